// File: rtl/game_controller.sv
// TicTacToe game-state sequencer: button edge detection, board/cursor/player, win/draw detection.
// Define GAME_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES-long debounce stage ahead of edge detection.
module game_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        select,
    input  logic        start,
    output logic        ce_ss,
    output logic        ce_ps,
    output logic        ce_ws,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic        player,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic [3:0]  move_count
);

    localparam logic [1:0] SS = 2'd0;
    localparam logic [1:0] PS = 2'd1;
    localparam logic [1:0] CK = 2'd2;
    localparam logic [1:0] WS = 2'd3;

    localparam int unsigned B_START  = 0;
    localparam int unsigned B_SELECT = 1;
    localparam int unsigned B_UP     = 2;
    localparam int unsigned B_DOWN   = 3;
    localparam int unsigned B_LEFT   = 4;
    localparam int unsigned B_RIGHT  = 5;

    localparam int unsigned LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    logic [5:0] raw, sync1, sync2, level, level_q, pulse;
    logic [1:0] state, state_n;
    logic [7:0] hits;
    logic [1:0] hit_mark;
    logic       cell_empty;

    assign raw = {right, left, down, up, select, start};

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level_q <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
        end
    end

`ifdef GAME_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt [6];
    logic [5:0]      db_level;

    // Counter runs only while the synchronized level differs from the accepted one.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            db_level <= '0;
            for (int unsigned i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 6; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    assign pulse = level & ~level_q;

    function automatic logic [1:0] line_mark(input logic [1:0] a, input logic [1:0] b,
                                             input logic [1:0] c);
        return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
    endfunction

    function automatic logic [3:0] step(input logic [3:0] c, input int unsigned dir);
        logic col0, col2;
        col0 = (c == 4'd0) || (c == 4'd3) || (c == 4'd6);
        col2 = (c == 4'd2) || (c == 4'd5) || (c == 4'd8);
        case (dir)
            B_UP:    return (c < 4'd3) ? c + 4'd6 : c - 4'd3;
            B_DOWN:  return (c > 4'd5) ? c - 4'd6 : c + 4'd3;
            B_LEFT:  return col0 ? c + 4'd2 : c - 4'd1;
            default: return col2 ? c - 4'd2 : c + 4'd1;
        endcase
    endfunction

    always_comb begin
        logic [1:0] m;
        m        = 2'b00;
        hits     = '0;
        hit_mark = 2'b00;
        for (int unsigned l = 0; l < 8; l++) begin
            m = line_mark(board[2*LINES[l][0] +: 2], board[2*LINES[l][1] +: 2],
                          board[2*LINES[l][2] +: 2]);
            if (m != 2'b00) begin
                hits[l]  = 1'b1;
                hit_mark = m;
            end
        end
    end

    assign cell_empty = (board[{cursor, 1'b0} +: 2] == 2'b00);

    always_comb begin
        state_n = state;
        case (state)
            SS: if (pulse[B_START]) state_n = PS;
            PS: if (pulse[B_SELECT] && cell_empty) state_n = CK;
            CK: state_n = (hits != '0 || move_count == 4'd9) ? WS : PS;
            WS: if (pulse[B_START]) state_n = SS;
            default: state_n = SS;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= SS;
            ce_ss <= 1'b1;
            ce_ps <= 1'b0;
            ce_ws <= 1'b0;
        end else begin
            state <= state_n;
            ce_ss <= (state_n == SS);
            ce_ps <= (state_n == PS) || (state_n == CK);
            ce_ws <= (state_n == WS);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            board      <= '0;
            cursor     <= 4'd4;
            player     <= 1'b0;
            winner     <= 2'b00;
            win_line   <= '0;
            move_count <= '0;
        end else begin
            case (state)
                SS: if (pulse[B_START]) begin
                    board      <= '0;
                    cursor     <= 4'd4;
                    player     <= 1'b0;
                    winner     <= 2'b00;
                    win_line   <= '0;
                    move_count <= '0;
                end
                // Select outranks arrows even when it lands on an occupied cell.
                PS: if (pulse[B_SELECT]) begin
                    if (cell_empty) begin
                        board[{cursor, 1'b0} +: 2] <= player ? 2'b10 : 2'b01;
                        move_count                 <= move_count + 4'd1;
                    end
                end else if (pulse[B_UP]) begin
                    cursor <= step(cursor, B_UP);
                end else if (pulse[B_DOWN]) begin
                    cursor <= step(cursor, B_DOWN);
                end else if (pulse[B_LEFT]) begin
                    cursor <= step(cursor, B_LEFT);
                end else if (pulse[B_RIGHT]) begin
                    cursor <= step(cursor, B_RIGHT);
                end
                CK: if (hits != '0) begin
                    winner   <= hit_mark;
                    win_line <= hits;
                end else if (move_count == 4'd9) begin
                    winner <= 2'b11;
                end else begin
                    player <= ~player;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller; the GAME_DEBOUNCE_EN build runs the debounce sequence.
module tb_game_controller;

    logic        clk_100MHz = 1'b0;
    logic        reset, up, down, left, right, select, start;
    logic        ce_ss, ce_ps, ce_ws, player;
    logic [17:0] board;
    logic [3:0]  cursor, move_count;
    logic [1:0]  winner;
    logic [7:0]  win_line;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cur   = 4;

`ifdef GAME_DEBOUNCE_EN
    localparam int DBC = 8;
    localparam int DBW = 4;
`else
    localparam int DBC = 1000000;
    localparam int DBW = 20;
`endif

    localparam logic [5:0] K_UP    = 6'b100000;
    localparam logic [5:0] K_DOWN  = 6'b010000;
    localparam logic [5:0] K_LEFT  = 6'b001000;
    localparam logic [5:0] K_RIGHT = 6'b000100;
    localparam logic [5:0] K_SEL   = 6'b000010;
    localparam logic [5:0] K_START = 6'b000001;

    game_controller #(.DEBOUNCE_CYCLES(DBC), .DB_W(DBW)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .up(up), .down(down), .left(left), .right(right),
        .select(select), .start(start),
        .ce_ss(ce_ss), .ce_ps(ce_ps), .ce_ws(ce_ws),
        .board(board), .cursor(cursor), .player(player),
        .winner(winner), .win_line(win_line), .move_count(move_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [5:0] b);
        {up, down, left, right, select, start} = b;
    endtask

    task automatic press(input logic [5:0] b, input int hold, input int settle);
        @(negedge clk_100MHz);
        set_btn(b);
        repeat (hold) @(negedge clk_100MHz);
        set_btn('0);
        repeat (settle) @(negedge clk_100MHz);
    endtask

    task automatic tap(input logic [5:0] b);
        press(b, 1, 4);
    endtask

    task automatic move_to(input int t);
        while (tb_cur / 3 != t / 3) begin
            tap(K_DOWN);
            tb_cur = (tb_cur + 3) % 9;
        end
        while (tb_cur % 3 != t % 3) begin
            tap(K_RIGHT);
            tb_cur = (tb_cur / 3) * 3 + (tb_cur % 3 + 1) % 3;
        end
        check("cursor_move", 32'(cursor), 32'(t));
    endtask

    task automatic place(input int t);
        move_to(t);
        tap(K_SEL);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ce_ss"}, 32'(ce_ss), 1);
        check({tag, "_ce_ps"}, 32'(ce_ps), 0);
        check({tag, "_ce_ws"}, 32'(ce_ws), 0);
        check({tag, "_board"}, 32'(board), 0);
        check({tag, "_cursor"}, 32'(cursor), 4);
        check({tag, "_player"}, 32'(player), 0);
        check({tag, "_winner"}, 32'(winner), 0);
        check({tag, "_win_line"}, 32'(win_line), 0);
        check({tag, "_move_count"}, 32'(move_count), 0);
    endtask

    initial begin
        set_btn('0);
        reset = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
        check_reset("rst");

`ifdef GAME_DEBOUNCE_EN
        press(K_START, 10, 30);
        check("db_start_ce_ps", 32'(ce_ps), 1);
        check("db_start_cursor", 32'(cursor), 4);
        press(K_RIGHT, 5, 30);
        check("db_glitch_cursor", 32'(cursor), 4);
        press(K_RIGHT, 10, 30);
        check("db_press_cursor", 32'(cursor), 5);
        check("db_move_count", 32'(move_count), 0);
`else
        // start raw high sampled at edge k, state change lands at edge k+2
        @(negedge clk_100MHz);
        start = 1'b1;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        start = 1'b0;
        @(posedge clk_100MHz);
        #1 check("start_k1_ce_ss", 32'(ce_ss), 1);
        @(posedge clk_100MHz);
        #1;
        check("start_ce_ps", 32'(ce_ps), 1);
        check("start_ce_ss", 32'(ce_ss), 0);
        check("start_cursor", 32'(cursor), 4);
        check("start_board", 32'(board), 0);
        check("start_player", 32'(player), 0);
        tb_cur = 4;

        tap(K_LEFT);  check("left_4", 32'(cursor), 3);
        tap(K_LEFT);  check("left_wrap", 32'(cursor), 5);
        tap(K_UP);    check("up_5", 32'(cursor), 2);
        tap(K_UP);    check("up_wrap", 32'(cursor), 8);
        tap(K_DOWN);  check("down_wrap", 32'(cursor), 2);
        tb_cur = 2;

        // Game 1: X takes the top row
        place(0);
        check("g1_board_x0", 32'(board), 32'h00001);
        check("g1_player_o", 32'(player), 1);
        place(3);
        place(1);
        place(4);
        move_to(2);
        @(negedge clk_100MHz);
        select = 1'b1;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        select = 1'b0;
        @(posedge clk_100MHz);
        @(posedge clk_100MHz);
        #1;
        check("g1_sel_move_count", 32'(move_count), 5);
        check("g1_sel_board", 32'(board), 32'h00295);
        check("g1_sel_winner", 32'(winner), 0);
        check("g1_sel_ce_ps", 32'(ce_ps), 1);
        @(posedge clk_100MHz);
        #1;
        check("g1_winner", 32'(winner), 1);
        check("g1_win_line", 32'(win_line), 1);
        check("g1_ce_ws", 32'(ce_ws), 1);
        check("g1_ce_ps", 32'(ce_ps), 0);
        check("g1_player", 32'(player), 0);
        repeat (2) @(negedge clk_100MHz);

        tap(K_UP);
        check("ws_up_cursor", 32'(cursor), 2);
        tap(K_START);
        check("ws_start_ce_ss", 32'(ce_ss), 1);
        check("ws_start_board", 32'(board), 32'h00295);
        check("ws_start_winner", 32'(winner), 1);
        tap(K_START);
        check("g2_ce_ps", 32'(ce_ps), 1);
        check("g2_board_clr", 32'(board), 0);
        check("g2_winner_clr", 32'(winner), 0);
        check("g2_win_line_clr", 32'(win_line), 0);
        check("g2_cursor", 32'(cursor), 4);
        tb_cur = 4;

        // Game 2: draw
        place(0); place(1); place(2); place(4); place(3);
        place(5); place(7); place(6); place(8);
        check("g2_board", 32'(board), 32'h16A59);
        check("g2_winner", 32'(winner), 3);
        check("g2_win_line", 32'(win_line), 0);
        check("g2_move_count", 32'(move_count), 9);
        check("g2_ce_ws", 32'(ce_ws), 1);

        tap(K_START);
        tap(K_START);
        tb_cur = 4;

        // Game 3: occupied select, select beats up, reset mid-game
        place(4);
        check("g3_board_x4", 32'(board), 32'h00100);
        tap(K_SEL);
        check("g3_occ_board", 32'(board), 32'h00100);
        check("g3_occ_move_count", 32'(move_count), 1);
        check("g3_occ_player", 32'(player), 1);
        check("g3_occ_ce_ps", 32'(ce_ps), 1);
        move_to(0);
        tap(K_UP | K_SEL);
        check("g3_upsel_board", 32'(board), 32'h00102);
        check("g3_upsel_cursor", 32'(cursor), 0);
        check("g3_upsel_move_count", 32'(move_count), 2);
        check("g3_upsel_player", 32'(player), 0);

        @(negedge clk_100MHz);
        reset = 1'b1;
        @(posedge clk_100MHz);
        #1 check_reset("midrst");
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
